// File: rtl/apb_uart_arbiter_pkg.sv
// Shared types and sizing helpers for the APB UART arbiter.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT + 1);

    // Width of the ACCESS wait counter; at least one bit so TIMEOUT=0 still elaborates.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_uart_arbiter_rr.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter
    import apb_uart_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any_grant
);

    logic [PW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Shares one APB UART completer among NREQ clients: round-robin grant,
// one SETUP/ACCESS transfer per grant, abort with rsp_err if PREADY never comes.
module apb_uart_arbiter
    import apb_uart_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH-1:0]      PRDATA,
    input  logic                       PREADY
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_e state_q, state_d;

    logic [NREQ-1:0]       grant;
    logic [PW-1:0]         grant_idx;
    logic                  any_grant;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         owner_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         cnt_q;
    logic                  expired;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_grant) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant strobe is suppressed during reset so no client believes it was accepted.
    always_comb begin
        PSEL      = (state_q != IDLE);
        PENABLE   = (state_q == ACCESS);
        req_ready = (state_q == IDLE && !rst) ? grant : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (state_q == IDLE && any_grant) begin
                owner_q <= grant_idx;
                wr_q    <= req_write[grant_idx];
                addr_q  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                ptr_q   <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == SETUP) cnt_q <= '0;
            if (state_q == ACCESS) begin
                if (PREADY) begin
                    rsp_valid <= NREQ'(1) << owner_q;
                    rsp_rdata <= wr_q ? '0 : PRDATA;
                    rsp_err   <= 1'b0;
                end else if (expired) begin
                    rsp_valid <= NREQ'(1) << owner_q;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign PWRITE = wr_q;
    assign PADDR  = addr_q;
    assign PWDATA = wdata_q;

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed bench for apb_uart_arbiter with two clients and a scripted completer.
module tb_apb_uart_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [NREQ-1:0] req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]  rsp_rdata, PWDATA, PRDATA;
    logic           rsp_err, PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0]  PADDR;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_uart_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0;
        tick(); tick();
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        rst = 1'b0;
        #1 chk("rst_req_ready", 32'(req_ready), 0);

        // Single read by client0, PREADY one ACCESS cycle late
        req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 5'h04;
        #1 chk("rd_ready_T0", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b00;
        chk("rd_psel_T1", 32'(PSEL), 1);
        chk("rd_penable_T1", 32'(PENABLE), 0);
        chk("rd_paddr_T1", 32'(PADDR), 32'h04);
        chk("rd_pwrite_T1", 32'(PWRITE), 0);
        tick();
        chk("rd_psel_T2", 32'(PSEL), 1);
        chk("rd_penable_T2", 32'(PENABLE), 1);
        chk("rd_rsp_T2", 32'(rsp_valid), 0);
        tick(); PREADY = 1'b1; PRDATA = 32'hA5A5_0001;
        chk("rd_penable_T3", 32'(PENABLE), 1);
        chk("rd_paddr_T3", 32'(PADDR), 32'h04);
        tick(); PREADY = 1'b0; PRDATA = '0;
        chk("rd_rsp_T4", 32'(rsp_valid), 32'h1);
        chk("rd_rdata_T4", rsp_rdata, 32'hA5A5_0001);
        chk("rd_err_T4", 32'(rsp_err), 0);
        chk("rd_psel_T4", 32'(PSEL), 0);
        chk("rd_penable_T4", 32'(PENABLE), 0);
        tick();
        chk("rd_rsp_T5", 32'(rsp_valid), 0);
        chk("rd_rdata_hold", rsp_rdata, 32'hA5A5_0001);

        // Single write by client1
        req_valid = 2'b10; req_write = 2'b10; req_addr[AW +: AW] = 5'h00; req_wdata[DW +: DW] = 32'h41;
        #1 chk("wr_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = 2'b00; req_write = 2'b00;
        chk("wr_pwrite_setup", 32'(PWRITE), 1);
        chk("wr_pwdata_setup", PWDATA, 32'h41);
        chk("wr_paddr_setup", 32'(PADDR), 0);
        tick(); PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
        chk("wr_pwrite_access", 32'(PWRITE), 1);
        chk("wr_pwdata_access", PWDATA, 32'h41);
        tick(); PREADY = 1'b0;
        chk("wr_rsp", 32'(rsp_valid), 32'h2);
        chk("wr_rdata", rsp_rdata, 0);
        chk("wr_err", 32'(rsp_err), 0);

        // Contention: both clients keep requesting; expect 0,1,0,1 back-to-back
        tick();
        req_addr[0 +: AW] = 5'h01; req_addr[AW +: AW] = 5'h02; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("cont_ready", 32'(req_ready), 32'(1 << (i % 2)));
            if (i > 0) begin
                chk("cont_rsp_b2b", 32'(rsp_valid), 32'(1 << ((i - 1) % 2)));
                chk("cont_rdata", rsp_rdata, 32'h100 + 32'(i - 1));
            end
            tick(); PREADY = 1'b1; PRDATA = 32'h100 + 32'(i);
            chk("cont_paddr", 32'(PADDR), 32'((i % 2) + 1));
            chk("cont_setup_pen", 32'(PENABLE), 0);
            tick();
            chk("cont_access_pen", 32'(PENABLE), 1);
            tick(); PREADY = 1'b0;
        end
        req_valid = 2'b00;
        chk("cont_rsp_last", 32'(rsp_valid), 32'h2);
        chk("cont_rdata_last", rsp_rdata, 32'h103);

        // Timeout: PREADY never rises, 16 ACCESS cycles then abort
        tick();
        req_addr[0 +: AW] = 5'h03; req_valid = 2'b01; PRDATA = 32'h0000_0BAD;
        #1 chk("to_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b00;
        chk("to_setup_psel", 32'(PSEL), 1);
        for (int k = 0; k < TO; k++) begin
            tick();
            chk("to_access_pen", 32'(PENABLE), 1);
            chk("to_access_rsp", 32'(rsp_valid), 0);
        end
        tick();
        chk("to_rsp", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_psel", 32'(PSEL), 0);
        req_valid = 2'b01;
        #1 chk("to_next_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b00;
        tick(); PREADY = 1'b1; PRDATA = 32'h55;
        tick(); PREADY = 1'b0;
        chk("to_next_rsp", 32'(rsp_valid), 32'h1);
        chk("to_next_err", 32'(rsp_err), 0);
        chk("to_next_rdata", rsp_rdata, 32'h55);

        // Reset mid-ACCESS: pointer (now 1) must return to 0, no response
        req_valid = 2'b01;
        tick(); req_valid = 2'b00;
        tick();
        chk("mr_in_access", 32'(PENABLE), 1);
        rst = 1'b1; PREADY = 1'b1; PRDATA = 32'h77;
        tick(); rst = 1'b0; PREADY = 1'b0;
        chk("mr_psel", 32'(PSEL), 0);
        chk("mr_penable", 32'(PENABLE), 0);
        chk("mr_rsp", 32'(rsp_valid), 0);
        req_valid = 2'b11;
        #1 chk("mr_grant_c0", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b00;
        tick(); PREADY = 1'b1; PRDATA = 32'h66;
        tick(); PREADY = 1'b0;
        chk("mr_next_rsp", 32'(rsp_valid), 32'h1);

        // Withdrawn request: client1 asserts then drops while client0 is busy
        req_valid = 2'b01;
        #1 chk("wd_ready_c0", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b10;
        #1 chk("wd_ready_setup", 32'(req_ready), 0);
        tick(); req_valid = 2'b00; PREADY = 1'b1; PRDATA = 32'h12;
        #1 chk("wd_ready_access", 32'(req_ready), 0);
        tick(); PREADY = 1'b0;
        chk("wd_rsp", 32'(rsp_valid), 32'h1);
        tick();
        chk("wd_no_grant", 32'(PSEL), 0);
        req_valid = 2'b11;
        #1 chk("wd_ptr_c1", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
